// File: rtl/lru_priority_updater.sv
// lru_priority_updater: per-set 2-bit age (LRU) state for a 4-way cache; updates ages on hit/fill and picks the miss victim
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   access_valid/ready  access handshake; access_set/hit/way describe the access
//   done, done_way/set  one-cycle commit pulse with the way made MRU and its set
//   flush, flush_busy   re-initialise all sets; busy during the sweep
//   query_set/prio      combinational read of a set's packed ages (way i at [2i+1:2i])
module lru_priority_updater #(
    parameter int NUM_SETS = 8,
    parameter int SET_W    = 3,
    parameter int NUM_WAYS = 4,
    parameter int AGE_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      access_valid,
    output logic                      access_ready,
    input  logic [SET_W-1:0]          access_set,
    input  logic                      access_hit,
    input  logic [1:0]                access_way,
    output logic                      done,
    output logic [1:0]                done_way,
    output logic [SET_W-1:0]          done_set,
    input  logic                      flush,
    output logic                      flush_busy,
    input  logic [SET_W-1:0]          query_set,
    output logic [NUM_WAYS*AGE_W-1:0] query_prio
);
    typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, FLUSH} state_t;
    localparam int PW = NUM_WAYS * AGE_W;
    function automatic logic [PW-1:0] init_ages();
        logic [PW-1:0] v;
        for (int i = 0; i < NUM_WAYS; i++) v[i*AGE_W +: AGE_W] = AGE_W'(i);
        return v;
    endfunction
    localparam logic [PW-1:0] INIT = init_ages();
    localparam logic [AGE_W-1:0] AGE_LRU = '1;
    state_t             state_q, state_d;
    logic [PW-1:0]      ages_q [NUM_SETS];
    logic [PW-1:0]      ages_d [NUM_SETS];
    logic [SET_W-1:0]   set_q, set_d, cnt_q, cnt_d;
    logic               hit_q, hit_d;
    logic [1:0]         way_q, way_d, tgt_q, tgt_d, victim;
    logic [AGE_W-1:0]   ref_q, ref_d, a;
    logic [PW-1:0]      cur;
    assign cur          = ages_q[set_q];
    assign query_prio   = ages_q[query_set];
    assign access_ready = (state_q == IDLE) && !flush;
    assign flush_busy   = (state_q == FLUSH);
    assign done         = (state_q == WRITE);
    assign done_way     = tgt_q;
    assign done_set     = set_q;
    always_comb begin
        victim = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            if (cur[i*AGE_W +: AGE_W] == AGE_LRU) victim = 2'(i);
    end
    always_comb begin
        state_d = state_q;
        ages_d  = ages_q;
        set_d   = set_q;
        hit_d   = hit_q;
        way_d   = way_q;
        tgt_d   = tgt_q;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        a       = '0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (access_valid) begin
                    state_d = LOOKUP;
                    set_d   = access_set;
                    hit_d   = access_hit;
                    way_d   = access_way;
                end
            end
            LOOKUP: begin
                tgt_d   = hit_q ? way_q : victim;
                ref_d   = cur[tgt_d*AGE_W +: AGE_W];
                state_d = WRITE;
            end
            WRITE: begin
                // only ages strictly below ref_q (itself <= 3) increment, so no age ever wraps
                for (int i = 0; i < NUM_WAYS; i++) begin
                    a = cur[i*AGE_W +: AGE_W];
                    ages_d[set_q][i*AGE_W +: AGE_W] = (tgt_q == 2'(i)) ? '0 :
                                                      (a < ref_q) ? a + AGE_W'(1) : a;
                end
                state_d = IDLE;
            end
            FLUSH: begin
                ages_d[cnt_q] = INIT;
                cnt_d         = cnt_q + SET_W'(1);
                state_d       = (cnt_q == SET_W'(NUM_SETS - 1)) ? IDLE : FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ages_q  <= '{default: INIT};
            set_q   <= '0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            tgt_q   <= '0;
            ref_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ages_q  <= ages_d;
            set_q   <= set_d;
            hit_q   <= hit_d;
            way_q   <= way_d;
            tgt_q   <= tgt_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_lru_priority_updater.sv
// tb_lru_priority_updater: scoreboard bench for lru_priority_updater with directed vectors
module tb_lru_priority_updater;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       access_valid = 1'b0;
    logic       access_ready;
    logic [2:0] access_set = '0;
    logic       access_hit = 1'b0;
    logic [1:0] access_way = '0;
    logic       done;
    logic [1:0] done_way;
    logic [2:0] done_set;
    logic       flush = 1'b0;
    logic       flush_busy;
    logic [2:0] query_set = '0;
    logic [7:0] query_prio;
    int total = 0;
    int bad = 0;
    logic [4:0] exp_q [$];
    lru_priority_updater dut (
        .clk(clk), .reset(reset),
        .access_valid(access_valid), .access_ready(access_ready),
        .access_set(access_set), .access_hit(access_hit), .access_way(access_way),
        .done(done), .done_way(done_way), .done_set(done_set),
        .flush(flush), .flush_busy(flush_busy),
        .query_set(query_set), .query_prio(query_prio)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got set=%0d way=%0d expected no pulse", done_set, done_way);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                chk("done_set", 32'(done_set), 32'(e[4:2]));
                chk("done_way", 32'(done_way), 32'(e[1:0]));
            end
        end
    end
    task automatic query(input logic [2:0] s, input logic [7:0] exp);
        query_set = s;
        #1;
        chk($sformatf("prio_set%0d", s), 32'(query_prio), 32'(exp));
    endtask
    task automatic access(input logic [2:0] s, input logic h, input logic [1:0] w, input logic [1:0] ew);
        @(negedge clk);
        chk("ready_before", 32'(access_ready), 1);
        access_valid = 1'b1;
        access_set = s;
        access_hit = h;
        access_way = w;
        exp_q.push_back({s, ew});
        @(posedge clk);
        #1 access_valid = 1'b0;
        @(negedge clk) chk("ready_lookup", 32'(access_ready), 0);
        @(negedge clk) chk("ready_write", 32'(access_ready), 0);
        @(negedge clk) chk("ready_after", 32'(access_ready), 1);
        chk("queue_drained", 32'(exp_q.size()), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(access_ready), 1);
        chk("reset_done", 32'(done), 0);
        chk("reset_busy", 32'(flush_busy), 0);
        chk("reset_done_way", 32'(done_way), 0);
        chk("reset_done_set", 32'(done_set), 0);
        for (int s = 0; s < 8; s++) query(3'(s), 8'hE4);
        access(3'd2, 1'b0, 2'd0, 2'd3);
        query(3'd2, 8'h39);
        access(3'd5, 1'b1, 2'd1, 2'd1);
        query(3'd5, 8'hE1);
        access(3'd5, 1'b1, 2'd1, 2'd1);
        query(3'd5, 8'hE1);
        access(3'd0, 1'b0, 2'd2, 2'd3);
        query(3'd0, 8'h39);
        access(3'd0, 1'b0, 2'd1, 2'd2);
        query(3'd0, 8'h4E);
        access(3'd0, 1'b0, 2'd0, 2'd1);
        query(3'd0, 8'h93);
        access(3'd0, 1'b0, 2'd3, 2'd0);
        query(3'd0, 8'hE4);
        access(3'd4, 1'b1, 2'd2, 2'd2);
        query(3'd4, 8'hC9);
        // flush with a simultaneous access: access must be dropped
        @(negedge clk);
        flush = 1'b1;
        access_valid = 1'b1;
        access_set = 3'd3;
        access_hit = 1'b0;
        #1 chk("ready_flush_req", 32'(access_ready), 0);
        @(posedge clk);
        #1 begin
            flush = 1'b0;
            access_valid = 1'b0;
        end
        n = 0;
        @(negedge clk);
        chk("ready_in_flush", 32'(access_ready), 0);
        while (flush_busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("flush_cycles", n, 8);
        chk("ready_after_flush", 32'(access_ready), 1);
        for (int s = 0; s < 8; s++) query(3'(s), 8'hE4);
        access(3'd4, 1'b1, 2'd2, 2'd2);
        query(3'd4, 8'hC9);
        // reset during WRITE of a set-4 miss: no done pulse, set re-initialised
        @(negedge clk);
        access_valid = 1'b1;
        access_set = 3'd4;
        access_hit = 1'b0;
        @(posedge clk);
        #1 access_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_done", 32'(done), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_mid_ready", 32'(access_ready), 1);
        chk("reset_mid_busy", 32'(flush_busy), 0);
        query(3'd4, 8'hE4);
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
